// File: rtl/mdu_e_stage.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div with HI/LO and busy flag.
// Optional madd/maddu accumulate support is enabled by defining MDU_MADD_EN.
module mdu_e_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_md_start,
    input  logic [2:0]  e_md_op,
    input  logic [31:0] e_md_a,
    input  logic [31:0] e_md_b,
    input  logic        e_md_rd_sel,
    output logic        e_md_busy,
    output logic [31:0] e_md_rdata
);
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [3:0]         cnt;
    logic [31:0]        hi, lo, p_hi, p_lo;
    logic [31:0]        res_hi, res_lo;
    logic               is_mul, is_div, is_madd, busy_op, idle;
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
`ifdef MDU_MADD_EN
    logic [63:0]        acc_s, acc_u;
`endif

    always_comb begin
        is_mul  = (e_md_op == 3'd0) || (e_md_op == 3'd1);
        is_div  = (e_md_op == 3'd2) || (e_md_op == 3'd3);
`ifdef MDU_MADD_EN
        is_madd = (e_md_op[2:1] == 2'b11);
`else
        is_madd = 1'b0;
`endif
        busy_op = is_mul | is_div | is_madd;
        idle    = (cnt == 4'd0);
    end

    assign e_md_busy  = !idle | (e_md_start & busy_op);
    assign e_md_rdata = e_md_rd_sel ? lo : hi;

    assign prod_s = $signed({{32{e_md_a[31]}}, e_md_a}) * $signed({{32{e_md_b[31]}}, e_md_b});
    assign prod_u = {32'd0, e_md_a} * {32'd0, e_md_b};
    assign quo_s  = $signed(e_md_a) / $signed(e_md_b);
    assign rem_s  = $signed(e_md_a) % $signed(e_md_b);
    assign quo_u  = e_md_a / e_md_b;
    assign rem_u  = e_md_a % e_md_b;
`ifdef MDU_MADD_EN
    assign acc_s  = {hi, lo} + prod_s;
    assign acc_u  = {hi, lo} + prod_u;
`endif

    // Divide by zero leaves the current HI/LO as the pending result.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (e_md_op)
            3'd0: {res_hi, res_lo} = prod_s;
            3'd1: {res_hi, res_lo} = prod_u;
            3'd2: begin
                if (e_md_b != 32'd0) begin
                    if (e_md_a == 32'h8000_0000 && e_md_b == 32'hFFFF_FFFF) begin
                        res_hi = 32'd0;
                        res_lo = 32'h8000_0000;
                    end else begin
                        res_hi = rem_s;
                        res_lo = quo_s;
                    end
                end
            end
            3'd3: begin
                if (e_md_b != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
`ifdef MDU_MADD_EN
            3'd6: {res_hi, res_lo} = acc_s;
            3'd7: {res_hi, res_lo} = acc_u;
`endif
            default: ;
        endcase
    end

    // Any start while cnt is non-zero is dropped, including mthi/mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 4'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
        end else if (!idle) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else if (e_md_start) begin
            if (busy_op) begin
                cnt  <= is_div ? DIV_N : MULT_N;
                p_hi <= res_hi;
                p_lo <= res_lo;
            end else if (e_md_op == 3'd4) begin
                hi <= e_md_a;
            end else if (e_md_op == 3'd5) begin
                lo <= e_md_a;
            end
        end
    end
endmodule

// File: doc/mdu_e_stage.md
Name: mdu_e_stage

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipelined MIPS core.
- Executes mult/multu/div/divu as multi-cycle operations and holds the HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Drives a busy flag; the hazard unit uses it to stall dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  core clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- e_md_start  input  1  one-cycle pulse: md instruction issuing from E (not stalled)
- e_md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
- e_md_a  input  32  forwarded rs value
- e_md_b  input  32  forwarded rt value
- e_md_rd_sel  input  1  read select: 0 = HI, 1 = LO
- e_md_busy  output  1  operation in flight or starting this cycle
- e_md_rdata  output  32  selected HI or LO for mfhi/mflo

Behaviour:
- Reset (asynchronous, active-high; clock is clk): HI=0, LO=0, counter=0, pending result cleared, e_md_busy=0, e_md_rdata=0.
- Reset mid-operation aborts the operation; no HI/LO commit follows.
- State: 4-bit down-counter cnt, pending registers p_hi/p_lo, committed HI/LO.
- Busy: e_md_busy = (cnt != 0) | (e_md_start & op in {0,1,2,3}, plus {6,7} when enabled). Combinational on start so the dependent instruction in D stalls in the same cycle.
- Start of mult/multu/div/divu, accepted only when cnt==0:
  - Result is computed from operands on that edge into p_hi/p_lo.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- Each clock with cnt!=0: cnt decrements. On the 1->0 transition, HI<=p_hi and LO<=p_lo.
- New values are visible on e_md_rdata in the first cycle busy is low.
- Latency: start at edge T; busy high during cycles T..T+N; HI/LO updated at edge T+N+1 (N = cycle parameter, T = start cycle).
- mthi/mtlo (start with op 4/5) when cnt==0: HI or LO <= e_md_a at that edge. Not busy-generating. Visible next cycle.
- Start while cnt!=0 is a pipeline protocol violation. It is ignored: no state change, in-flight operation continues.
- mult: signed 32x32 -> 64; {HI,LO} = product.
- multu: unsigned 32x32 -> 64; {HI,LO} = product.
- div/divu: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Divide by zero (e_md_b==0): busy for DIV_CYCLES as normal; HI/LO keep their prior values at commit (p_hi/p_lo loaded with current HI/LO).
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- e_md_rdata: combinational mux of committed HI/LO by e_md_rd_sel. Pending results are never exposed.
- Op 6/7 without feature: start ignored, busy not asserted, no state change.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 6 madd ({HI,LO} += signed a*b) and op 7 maddu (unsigned), 64-bit wrap-around add.
  - Accumulate base is HI/LO at the start edge.
  - Latency MULT_CYCLES; same busy/commit rules as mult.
- Undefined: ops 6/7 are no-ops as above; no accumulate adder is synthesised.

Test Plan:
- mult, a=0xFFFFFFFF, b=2 -> busy high 6 cycles (MULT_CYCLES=5); then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands via multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div, a=0xFFFFFFF9 (-7), b=2 -> after busy drops (11 cycles): LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, a=7, b=2 -> LO=3, HI=1.
- mthi a=0x12345678, then divu a=5, b=0 -> HI stays 0x12345678, LO stays 0 after 11 busy cycles. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult 3*4, second start (mult 5*5) issued 2 cycles later while busy -> ignored; final LO=12, HI=0; busy timing unchanged.
- reset pulse asserted asynchronously mid-div (cnt=4) -> busy=0 immediately, HI=LO=0, no commit on later edges; a new mult 2*3 afterwards gives LO=6.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu a=1, b=1 -> HI=1, LO=0. Without MDU_MADD_EN: the same op leaves HI=0, LO=0xFFFFFFFF and busy never rises.
